pulse_stretcher: RTL and testbench

- Inverse companion to the input debouncer. The debouncer compresses a long, noisy level into one clean single-cycle pulse; this block expands each single-cycle event pulse into a clean, fixed-length high level followed by a guaranteed low gap.
- Typical loads: LED indicators, emulated button presses toward downstream logic, and debouncer self-test stimulus.
- Events that arrive while an output period is in progress are queued in a saturating pending counter and replayed in order.

---
 rtl/pulse_stretcher.sv | 71 +++++++
 tb/tb_pulse_stretcher.sv | 135 +++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: expands single-cycle events into fixed-length highs separated by guaranteed low gaps.
module pulse_stretcher #(
   parameter int HOLD_CYCLES = 127,
   parameter int GAP_CYCLES  = 127,
   parameter int QUEUE_BITS  = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pulse_in,
   output logic                  level_out,
   output logic                  busy,
   output logic [QUEUE_BITS-1:0] pending,
   output logic                  overflow
);
   localparam int CW = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
   localparam logic [QUEUE_BITS-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          last;

   assign last = cnt == '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         level_out <= 1'b0;
         busy      <= 1'b0;
         pending   <= '0;
         overflow  <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (state == IDLE) begin
            if (pulse_in) begin
               state     <= HOLD;
               cnt       <= HOLD_LOAD;
               level_out <= 1'b1;
               busy      <= 1'b1;
            end
         end else if (state == GAP && last) begin
            // a new event on the final gap edge cancels against the replayed one
            if (pending != '0 || pulse_in) begin
               state     <= HOLD;
               cnt       <= HOLD_LOAD;
               level_out <= 1'b1;
               if (!pulse_in) pending <= pending - 1'b1;
            end else begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else begin
            if (state == HOLD && last) begin
               state     <= GAP;
               cnt       <= GAP_LOAD;
               level_out <= 1'b0;
            end else begin
               cnt <= cnt - 1'b1;
            end
            if (pulse_in) begin
               if (pending == PEND_MAX) overflow <= 1'b1;
               else pending <= pending + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed test-plan sequences plus random traffic on two configurations, checked against a position-based model.
module tb_pulse_stretcher;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pulse_in = 1'b0;
   logic       lvl_a, busy_a, ovf_a, lvl_b, busy_b, ovf_b;
   logic [1:0] pend_a, pend_b;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   pulse_stretcher #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .QUEUE_BITS(2)) dut_a (
      .clk(clk), .reset(reset), .pulse_in(pulse_in),
      .level_out(lvl_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a));

   pulse_stretcher #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .QUEUE_BITS(2)) dut_b (
      .clk(clk), .reset(reset), .pulse_in(pulse_in),
      .level_out(lvl_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b));

   // A period is H+G cycles long; pos counts cycles since the current hold began.
   typedef struct {
      bit act;
      int pos;
      int pend;
      bit ovf;
   } model_t;

   model_t ma, mb;

   function automatic model_t advance(model_t s, bit r, bit p, int h, int g, int mx);
      model_t n = s;
      n.ovf = 1'b0;
      if (r) begin
         n.act = 1'b0;
         n.pos = 0;
         n.pend = 0;
      end else if (!s.act) begin
         if (p) begin
            n.act = 1'b1;
            n.pos = 0;
         end
      end else if (s.pos == h + g - 1) begin
         if (s.pend > 0 || p) begin
            n.pos = 0;
            if (!p) n.pend = s.pend - 1;
         end else begin
            n.act = 1'b0;
         end
      end else begin
         n.pos = s.pos + 1;
         if (p) begin
            if (s.pend == mx) n.ovf = 1'b1;
            else n.pend = s.pend + 1;
         end
      end
      return n;
   endfunction

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(bit r, bit p);
      reset = r;
      pulse_in = p;
      @(posedge clk);
      ma = advance(ma, r, p, 4, 3, 3);
      mb = advance(mb, r, p, 1, 1, 3);
      #1;
      chk("a_level", int'(lvl_a), int'(ma.act && ma.pos < 4));
      chk("a_busy", int'(busy_a), int'(ma.act));
      chk("a_pending", int'(pend_a), ma.pend);
      chk("a_overflow", int'(ovf_a), int'(ma.ovf));
      chk("b_level", int'(lvl_b), int'(mb.act && mb.pos < 1));
      chk("b_busy", int'(busy_b), int'(mb.act));
      chk("b_pending", int'(pend_b), mb.pend);
      chk("b_overflow", int'(ovf_b), int'(mb.ovf));
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic pulses(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      // single event after a 2-cycle reset
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      idle(7);
      pulses(1);
      idle(12);
      chk("a_idle_after_single", int'(busy_a), 0);
      // queued events: pulses at relative edges 0, 2, 3
      pulses(1);
      idle(1);
      pulses(2);
      idle(30);
      // saturation and overflow
      pulses(5);
      idle(40);
      // second pulse exactly on the final gap edge
      pulses(1);
      idle(6);
      pulses(1);
      idle(20);
      // reset mid-hold with queued events and pulse_in high
      pulses(3);
      step(1'b1, 1'b1);
      chk("a_pending_after_reset", int'(pend_a), 0);
      idle(10);
      pulses(1);
      idle(15);
      // continuous input, exercises cancel on final gap for the 1/1 instance
      pulses(20);
      idle(40);
      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         int dens = (i / 300) % 3;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 7) < 1 + 3 * dens);
      end
      idle(40);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
